// File: rtl/alu_mdu_seq.sv
// Multi-cycle MUL/DIVU/REMU sequencer that borrows the shared execute-stage ALU.
// Optional macro MDU_EARLY_EXIT_EN: MUL finishes as soon as the remaining multiplier is zero.
module alu_mdu_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_mdu_op,
  input  logic [XLEN-1:0] i_operand_a,
  input  logic [XLEN-1:0] i_operand_b,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result,
  output logic            o_alu_sel,
  output logic [XLEN-1:0] o_alu_operand_a,
  output logic [XLEN-1:0] o_alu_operand_b,
  output logic [3:0]      o_alu_op,
  input  logic [XLEN-1:0] i_alu_data
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

`ifdef MDU_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MUL_STEP = 3'd1,
    S_DIV_CMP  = 3'd2,
    S_DIV_SUB  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_op, w_op_nxt;
  logic [XLEN-1:0]   r_acc, w_acc_nxt;
  logic [XLEN-1:0]   r_mcand, w_mcand_nxt;
  logic [XLEN-1:0]   r_mplier, w_mplier_nxt;
  logic [XLEN-1:0]   r_rem, w_rem_nxt;
  logic [XLEN-1:0]   r_dvd, w_dvd_nxt;
  logic [XLEN-1:0]   r_q, w_q_nxt;
  logic [XLEN-1:0]   r_divisor, w_divisor_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              r_lt, w_lt_nxt;
  logic [XLEN-1:0]   r_result, w_result_nxt;
  logic              r_done, w_done_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_alu_sel, w_alu_sel_nxt;
  logic [XLEN-1:0]   r_alu_a, w_alu_a_nxt;
  logic [XLEN-1:0]   r_alu_b, w_alu_b_nxt;
  logic [3:0]        r_alu_op, w_alu_op_nxt;
  logic [XLEN-1:0]   w_rem_sh;

  // Partial remainder with the next dividend bit shifted in (low 32 of the 33-bit value).
  assign w_rem_sh = {r_rem[XLEN-2:0], r_dvd[XLEN-1]};

  // Next state, datapath updates, and the ALU drive for the upcoming cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_acc_nxt     = r_acc;
    w_mcand_nxt   = r_mcand;
    w_mplier_nxt  = r_mplier;
    w_rem_nxt     = r_rem;
    w_dvd_nxt     = r_dvd;
    w_q_nxt       = r_q;
    w_divisor_nxt = r_divisor;
    w_cnt_nxt     = r_cnt;
    w_ovf_nxt     = r_ovf;
    w_lt_nxt      = r_lt;
    w_result_nxt  = r_result;
    w_alu_sel_nxt = 1'b0;
    w_alu_a_nxt   = '0;
    w_alu_b_nxt   = '0;
    w_alu_op_nxt  = ALU_ADD;

    unique case (r_state)
      S_IDLE: begin
        if (i_start && !i_kill) begin
          w_op_nxt      = i_mdu_op;
          w_divisor_nxt = i_operand_b;
          w_cnt_nxt     = '0;
          unique case (i_mdu_op)
            OP_MUL: begin
              w_acc_nxt    = '0;
              w_mcand_nxt  = i_operand_a;
              w_mplier_nxt = i_operand_b;
              w_state_nxt  = S_MUL_STEP;
            end
            OP_DIVU, OP_REMU: begin
              if (i_operand_b == '0) begin
                w_result_nxt = (i_mdu_op == OP_DIVU) ? '1 : i_operand_a;
                w_state_nxt  = S_DONE;
              end else begin
                w_rem_nxt   = '0;
                w_dvd_nxt   = i_operand_a;
                w_q_nxt     = '0;
                w_state_nxt = S_DIV_CMP;
              end
            end
            default: begin
              w_result_nxt = '0;
              w_state_nxt  = S_DONE;
            end
          endcase
        end
      end
      S_MUL_STEP: begin
        if (r_mplier[0]) w_acc_nxt = i_alu_data;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if ((r_cnt == LAST_CNT) || (EARLY_EXIT && (w_mplier_nxt == '0))) begin
          w_result_nxt = w_acc_nxt;
          w_state_nxt  = S_DONE;
        end
      end
      S_DIV_CMP: begin
        w_ovf_nxt   = r_rem[XLEN-1];
        w_lt_nxt    = i_alu_data[0];
        w_rem_nxt   = w_rem_sh;
        w_dvd_nxt   = r_dvd << 1;
        w_state_nxt = S_DIV_SUB;
      end
      S_DIV_SUB: begin
        // A lost carry-out means the true remainder exceeds any 32-bit divisor.
        if (r_ovf || !r_lt) begin
          w_rem_nxt = i_alu_data;
          w_q_nxt   = {r_q[XLEN-2:0], 1'b1};
        end else begin
          w_q_nxt   = {r_q[XLEN-2:0], 1'b0};
        end
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == LAST_CNT) begin
          w_result_nxt = (r_op == OP_DIVU) ? w_q_nxt : w_rem_nxt;
          w_state_nxt  = S_DONE;
        end else begin
          w_state_nxt  = S_DIV_CMP;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (i_kill && (r_state != S_IDLE)) begin
      w_state_nxt  = S_IDLE;
      w_result_nxt = r_result;
    end

    unique case (w_state_nxt)
      S_MUL_STEP: begin
        w_alu_sel_nxt = 1'b1;
        w_alu_a_nxt   = w_acc_nxt;
        w_alu_b_nxt   = w_mcand_nxt;
        w_alu_op_nxt  = ALU_ADD;
      end
      S_DIV_CMP: begin
        w_alu_sel_nxt = 1'b1;
        w_alu_a_nxt   = {w_rem_nxt[XLEN-2:0], w_dvd_nxt[XLEN-1]};
        w_alu_b_nxt   = w_divisor_nxt;
        w_alu_op_nxt  = ALU_SLTU;
      end
      S_DIV_SUB: begin
        w_alu_sel_nxt = 1'b1;
        w_alu_a_nxt   = w_rem_nxt;
        w_alu_b_nxt   = w_divisor_nxt;
        w_alu_op_nxt  = ALU_SUB;
      end
      default: begin
        w_alu_sel_nxt = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_q       <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_lt      <= 1'b0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_alu_sel <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= ALU_ADD;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_acc     <= w_acc_nxt;
      r_mcand   <= w_mcand_nxt;
      r_mplier  <= w_mplier_nxt;
      r_rem     <= w_rem_nxt;
      r_dvd     <= w_dvd_nxt;
      r_q       <= w_q_nxt;
      r_divisor <= w_divisor_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ovf     <= w_ovf_nxt;
      r_lt      <= w_lt_nxt;
      r_result  <= w_result_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
      r_alu_sel <= w_alu_sel_nxt;
      r_alu_a   <= w_alu_a_nxt;
      r_alu_b   <= w_alu_b_nxt;
      r_alu_op  <= w_alu_op_nxt;
    end
  end

  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_result        = r_result;
  assign o_alu_sel       = r_alu_sel;
  assign o_alu_operand_a = r_alu_a;
  assign o_alu_operand_b = r_alu_b;
  assign o_alu_op        = r_alu_op;

endmodule

// File: doc/alu_mdu_seq.md
Name: alu_mdu_seq

Overview:
- Multi-cycle sequencer that computes RV32M-subset MUL, DIVU and REMU by driving the core's shared 32-bit combinational ALU over many cycles.
- Runs shift-add multiplication and restoring division, issuing one ALU operation per cycle.
- Sits beside the execute stage. The ALU operand mux selects this block's operands while o_alu_sel is high, and the pipeline stalls while o_busy is high.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  request pulse; sampled only in IDLE.
- i_mdu_op  in  2  operation: 00 MUL (low 32), 01 DIVU, 10 REMU, 11 reserved.
- i_operand_a  in  32  multiplicand or dividend; latched when i_start is accepted.
- i_operand_b  in  32  multiplier or divisor; latched when i_start is accepted.
- i_kill  in  1  synchronous abort (pipeline flush).
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse; o_result is valid in that cycle.
- o_result  out  32  last completed result; held until the next o_done.
- o_alu_sel  out  1  high while the block owns the ALU (MUL_STEP, DIV_CMP, DIV_SUB).
- o_alu_operand_a  out  32  ALU operand A.
- o_alu_operand_b  out  32  ALU operand B.
- o_alu_op  out  4  ALU opcode: 0000 ADD, 1000 SUB, 0011 SLTU.
- i_alu_data  in  32  combinational ALU result, same cycle.

Behaviour:
- Reset, asynchronous: state IDLE, all internal registers 0, all outputs 0 (o_alu_op = 0000).
- States: IDLE, MUL_STEP, DIV_CMP, DIV_SUB, DONE.
- IDLE:
  - i_start=1 latches the operands and op and clears the counter.
  - MUL goes to MUL_STEP with acc=0, mcand=a, mplier=b.
  - DIVU/REMU with b!=0 go to DIV_CMP with rem=0, dvd=a, q=0.
  - DIVU/REMU with b==0 go straight to DONE: DIVU result 0xFFFFFFFF, REMU result = a.
  - Op 11 goes straight to DONE with result 0.
- MUL_STEP, per cycle:
  - Drive a=acc, b=mcand, op ADD.
  - If mplier[0], acc<=i_alu_data.
  - mcand<<=1, mplier>>=1, cnt++.
  - After the cnt==31 step, go to DONE.
  - Arithmetic is modulo 2^32.
- DIV_CMP:
  - rem_sh={rem[30:0],dvd[31]}; ovf<=rem[31].
  - Drive a=rem_sh, b=divisor, op SLTU.
  - lt<=i_alu_data[0], rem<=rem_sh, dvd<<=1.
  - Go to DIV_SUB.
- DIV_SUB:
  - Drive a=rem, b=divisor, op SUB.
  - If ovf|!lt: rem<=i_alu_data and shift 1 into q; else shift 0 into q.
  - cnt++. After the cnt==31 step go to DONE, else back to DIV_CMP.
- DONE:
  - o_done=1 and o_result updates in this cycle: acc, q or rem, by op.
  - Next state IDLE.
- Latency, from the edge that samples i_start to the cycle with o_done high:
  - MUL: 33.
  - DIVU/REMU: 65.
  - Divide-by-zero and op 11: 1.
  - Back-to-back: i_start in the cycle after o_done is accepted.
- i_start while o_busy=1 is ignored; it is neither queued nor errored.
- i_kill=1 in any non-IDLE state:
  - Next state IDLE.
  - No o_done, o_result unchanged.
  - i_kill has priority over i_start and over the DONE transition.
- Reset mid-operation behaves like i_kill, except o_result also clears to 0.
- Whenever o_alu_sel=0, o_alu_operand_a, o_alu_operand_b and o_alu_op are all 0.

Optional Feature:
- Macro: MDU_EARLY_EXIT_EN.
- Defined: in MUL_STEP, if the next mplier (after the shift) is 0, go to DONE immediately. MUL latency becomes 2 + index of the highest set bit of b; b==0 gives latency 2. Results are identical to the non-early-exit case.
- Undefined: MUL latency is always 33.
- DIVU/REMU timing is the same in both builds.

Test Plan (the bench connects the block to an alu instance through o_alu_* and i_alu_data):
- MUL a=7, b=6 -> o_result=42, o_done exactly 33 cycles after start (with early exit: 4 cycles).
- MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> o_result=0x00000001, one o_done pulse, o_busy low the following cycle.
- DIVU 100/7 -> 14 and REMU 100/7 -> 2, each with latency 65; issued back-to-back, the second start is accepted in the cycle after the first o_done.
- Overflow path: DIVU 0xFFFFFFFF/0x80000001 -> 1; REMU same operands -> 0x7FFFFFFE; DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Divide-by-zero: DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, each with latency 1; o_alu_sel never goes high.
- DIVU 100/7 with i_kill at cycle 20, plus i_start pulses at cycles 5 and 10 -> no o_done, o_result keeps its prior value, IDLE at cycle 21. Separately, i_rst_n low mid-MUL -> all outputs 0 immediately.
